// File: rtl/alu_hs.sv
// -----------------------------------------------------------------------------
// alu_hs
//   Registered WIDTH-bit ALU with Z/N/C/V flags and valid/ready handshakes on
//   both the operand and the result side. Keeps the 4-bit opcode map of the
//   older combinational ALU. When ALU_MUL_EN is defined, op 1110 becomes a
//   WIDTH-cycle shift-add multiply. When it is not defined, op 1110 behaves
//   like op 1111 (~A).
//
//   Configuration macro: ALU_MUL_EN
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   operands and opcode present
//     in_ready   block accepts operands this cycle
//     a, b       operands (WIDTH bits)
//     sel        4-bit opcode
//     out_valid  res/flags valid
//     out_ready  consumer accepts the result
//     res        result (WIDTH bits)
//     flag_z     res == 0
//     flag_n     res[WIDTH-1]
//     flag_c     unsigned carry / borrow / multiply high-half nonzero
//     flag_v     signed overflow (add/sub/inc/dec only)
// -----------------------------------------------------------------------------
module alu_hs #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } arith_t;

    // Overflow test: the WIDTH+1 signed result must equal the sign extension
    // of its own low WIDTH bits.
    function automatic arith_t add_op(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y);
        arith_t                o;
        logic        [WIDTH:0] u;
        logic signed [WIDTH:0] s;
        u   = {1'b0, x} + {1'b0, y};
        s   = $signed({x[WIDTH-1], x}) + $signed({y[WIDTH-1], y});
        o.r = u[WIDTH-1:0];
        o.c = u[WIDTH];
        o.v = (s != $signed({s[WIDTH-1], s[WIDTH-1:0]}));
        return o;
    endfunction

    // Borrow falls out as bit WIDTH of the zero-extended difference.
    function automatic arith_t sub_op(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y);
        arith_t                o;
        logic        [WIDTH:0] u;
        logic signed [WIDTH:0] s;
        u   = {1'b0, x} - {1'b0, y};
        s   = $signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y});
        o.r = u[WIDTH-1:0];
        o.c = u[WIDTH];
        o.v = (s != $signed({s[WIDTH-1], s[WIDTH-1:0]}));
        return o;
    endfunction

`ifdef ALU_MUL_EN
    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;
`else
    typedef enum logic {IDLE = 1'b0} state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic             xfer;
    logic             is_mul;
    arith_t           alu;

    logic [WIDTH-1:0] res_p1;
    logic             flag_z_p1;
    logic             flag_n_p1;
    logic             flag_c_p1;
    logic             flag_v_p1;
    logic             vld_p1;

    assign in_ready = (state_q == IDLE) && (!vld_p1 || out_ready);
    assign xfer     = in_valid && in_ready;

    // ---- stage p0: opcode decode / single-cycle datapath (combinational) ----
    always_comb begin
        alu = '0;
        case (sel)
            4'b0000: alu.r = ~a;
            4'b0001: alu.r = ~b;
            4'b0010: alu.r = a & b;
            4'b0011: alu.r = ~(a & b);
            4'b0100: alu.r = a | b;
            4'b0101: alu.r = ~(a | b);
            4'b0110: alu.r = a ^ b;
            4'b0111: alu.r = ~(a ^ b);
            4'b1000: alu   = add_op(a, ONE);
            4'b1001: alu   = sub_op(a, ONE);
            4'b1010: alu   = add_op(b, ONE);
            4'b1011: alu   = sub_op(b, ONE);
            4'b1100: alu   = add_op(a, b);
            4'b1101: alu   = sub_op(b, a);
            // 1110 without the multiplier, and 1111: ~A
            default: alu.r = ~a;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_p0;
    logic [2*WIDTH-1:0] mc_p0;
    logic [WIDTH-1:0]   mp_p0;
    logic [CW-1:0]      cnt_p0;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               last_step;

    assign is_mul    = (sel == 4'b1110);
    assign last_step = (state_q == MUL) && (cnt_p0 == CW'(WIDTH - 1));
    // The last step's sum is the full product, so the result loads on the
    // same edge that completes the final step.
    assign acc_nxt   = acc_p0 + (mp_p0[0] ? mc_p0 : '0);

    // ---- stage p0: shift-add multiplier, one partial product per cycle ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0 <= '0;
            mc_p0  <= '0;
            mp_p0  <= '0;
            cnt_p0 <= '0;
        end else if (xfer && is_mul) begin
            acc_p0 <= '0;
            mc_p0  <= {{WIDTH{1'b0}}, a};
            mp_p0  <= b;
            cnt_p0 <= '0;
        end else if (state_q == MUL) begin
            acc_p0 <= acc_nxt;
            mc_p0  <= mc_p0 << 1;
            mp_p0  <= mp_p0 >> 1;
            cnt_p0 <= last_step ? '0 : cnt_p0 + CW'(1);
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
`ifdef ALU_MUL_EN
        case (state_q)
            IDLE:    if (xfer && is_mul) state_d = MUL;
            MUL:     if (last_step)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- stage p1: result register, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1    <= '0;
            flag_z_p1 <= 1'b0;
            flag_n_p1 <= 1'b0;
            flag_c_p1 <= 1'b0;
            flag_v_p1 <= 1'b0;
            vld_p1    <= 1'b0;
        end else if (xfer && !is_mul) begin
            res_p1    <= alu.r;
            flag_z_p1 <= (alu.r == '0);
            flag_n_p1 <= alu.r[WIDTH-1];
            flag_c_p1 <= alu.c;
            flag_v_p1 <= alu.v;
            vld_p1    <= 1'b1;
`ifdef ALU_MUL_EN
        end else if (last_step) begin
            res_p1    <= acc_nxt[WIDTH-1:0];
            flag_z_p1 <= (acc_nxt[WIDTH-1:0] == '0);
            flag_n_p1 <= acc_nxt[WIDTH-1];
            flag_c_p1 <= |acc_nxt[2*WIDTH-1:WIDTH];
            flag_v_p1 <= 1'b0;
            vld_p1    <= 1'b1;
`endif
        end else if (out_ready) begin
            // Also covers a multiply issue: in_ready guaranteed the old
            // result was either absent or being drained on this edge.
            vld_p1    <= 1'b0;
        end
    end

    assign res       = res_p1;
    assign flag_z    = flag_z_p1;
    assign flag_n    = flag_n_p1;
    assign flag_c    = flag_c_p1;
    assign flag_v    = flag_v_p1;
    assign out_valid = vld_p1;

endmodule

// File: doc/alu_hs.md
# alu_hs

Registered, parametrised ALU with flag outputs and valid/ready handshakes on both the operand side and the result side. It keeps the established 4-bit opcode map and adds arithmetic flags and output back-pressure. It also adds an optional multi-cycle shift-add multiplier. It sits between an operand source (register file or sequencer) and a result consumer, and replaces the purely combinational 4-bit ALU wherever results must be pipelined or stalled.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sel  input  4  opcode
- out_valid  output  1  res/flags valid
- out_ready  input  1  consumer accepts result
- res  output  WIDTH  result
- flag_z  output  1  res == 0
- flag_n  output  1  res[WIDTH-1]
- flag_c  output  1  unsigned carry/borrow (see Operation)
- flag_v  output  1  signed overflow

## Operation
- Opcodes:
  - 0000 ~A, 0001 ~B, 0010 A&B, 0011 ~(A&B)
  - 0100 A|B, 0101 ~(A|B), 0110 A^B, 0111 ~(A^B)
  - 1000 A+1, 1001 A-1, 1010 B+1, 1011 B-1
  - 1100 A+B, 1101 B-A, 1110 A*B (low WIDTH bits), 1111 ~A
- All arithmetic is done at WIDTH+1 bits; res is the low WIDTH bits.
- flag_c: add/increment = bit WIDTH of the sum; subtract/decrement = 1 on borrow (minuend < subtrahend, unsigned); multiply = 1 if the upper WIDTH bits of the 2·WIDTH product are nonzero; logic ops = 0.
- flag_v: two's-complement overflow for add/sub/inc/dec; 0 for logic and multiply.
- flag_z and flag_n are computed from res for every op.
- A transfer occurs when in_valid && in_ready. a, b and sel are captured at that edge; later input changes are ignored.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Issue while the consumer drains the current result is allowed.
- State machine:
  - IDLE: accepting. A non-multiply op loads res/flags and sets out_valid at the same edge. Op 1110 enters MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles, with an internal step counter. After the last step, res/flags load, out_valid sets, and the state returns to IDLE.
- out_valid && !out_ready: res, flags and out_valid hold stable and in_ready is 0.
- out_valid && out_ready with no new transfer: out_valid clears at the edge.
- out_valid && out_ready with a simultaneous new single-cycle transfer: the new result replaces the old one and out_valid stays 1.

## Timing
- Reset (asynchronous, takes effect immediately): state = IDLE, out_valid = 0, res = 0, all flags = 0, step counter = 0. in_ready is 1 once rst_n is high.
- Reset during MUL aborts the operation; no result is produced.
- Single-cycle op latency: accepted at edge k, out_valid = 1 after edge k.
- Multiply latency: accepted at edge k, out_valid = 1 after edge k+WIDTH. in_ready = 0 for edges k+1 … k+WIDTH.
- Throughput: one single-cycle op per clock when out_ready is held at 1.
- The step counter is exactly $clog2(WIDTH)+1 bits wide and does not wrap past WIDTH.

## Configuration
- ALU_MUL_EN
  - Defined: op 1110 is the multi-cycle multiply described above, including the MUL state and its counter.
  - Undefined: no multiplier or MUL state is synthesised. Op 1110 behaves as 1111 (res = ~A, single cycle, flag_c = flag_v = 0), and in_ready never drops for op reasons.

## Test plan
- WIDTH=8, op 1100, a=0x0F, b=0xF1 -> res=0x00, z=1, c=1, v=0, n=0, out_valid one cycle after accept.
- op 1100, a=0x7F, b=0x01 -> res=0x80, v=1, n=1, c=0. Op 1101, a=0x05, b=0x03 -> res=0xFE, c=1, n=1, v=0.
- ALU_MUL_EN, op 1110, a=0x12, b=0x10 -> res=0x20, c=1, out_valid exactly 8 cycles after accept, in_ready=0 throughout. Repeat without ALU_MUL_EN -> res=0xED after 1 cycle.
- Back-pressure: result 0x3C pending, out_ready=0 for 3 cycles -> res/flags stable, in_ready=0. Raise out_ready with in_valid=1 (op 0010, a=0xF0, b=0x3C) -> new res=0x30 next cycle, out_valid stays 1.
- Back-to-back: 4 consecutive ops with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
- rst_n pulsed low at step 4 of a multiply -> out_valid=0, res=0, flags=0 immediately. Next op accepted normally after release.
